// File: rtl/aes_pkg.sv
// Shared constants and GF(2^8) helpers for the iterative AES inverse cipher.
// InvMixColumns coefficients are built from xtime chains, so no multipliers are inferred.
package aes_pkg;

  localparam int NB     = 4;
  localparam int NR_MAX = 14;
  localparam int KS_W   = 32 * NB * (NR_MAX + 1);

  typedef enum logic [1:0] {
    MODE_128 = 2'b00,
    MODE_192 = 2'b01,
    MODE_256 = 2'b10,
    MODE_RSV = 2'b11
  } mode_e;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_FINAL} fsm_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul_9(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b); x4 = xtime(x2); x8 = xtime(x4);
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul_b(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b); x4 = xtime(x2); x8 = xtime(x4);
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul_d(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b); x4 = xtime(x2); x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul_e(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b); x4 = xtime(x2); x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h00;
    case (x)
      8'h00: r = 8'h52; 8'h01: r = 8'h09; 8'h02: r = 8'h6a; 8'h03: r = 8'hd5; 8'h04: r = 8'h30; 8'h05: r = 8'h36; 8'h06: r = 8'ha5; 8'h07: r = 8'h38;
      8'h08: r = 8'hbf; 8'h09: r = 8'h40; 8'h0a: r = 8'ha3; 8'h0b: r = 8'h9e; 8'h0c: r = 8'h81; 8'h0d: r = 8'hf3; 8'h0e: r = 8'hd7; 8'h0f: r = 8'hfb;
      8'h10: r = 8'h7c; 8'h11: r = 8'he3; 8'h12: r = 8'h39; 8'h13: r = 8'h82; 8'h14: r = 8'h9b; 8'h15: r = 8'h2f; 8'h16: r = 8'hff; 8'h17: r = 8'h87;
      8'h18: r = 8'h34; 8'h19: r = 8'h8e; 8'h1a: r = 8'h43; 8'h1b: r = 8'h44; 8'h1c: r = 8'hc4; 8'h1d: r = 8'hde; 8'h1e: r = 8'he9; 8'h1f: r = 8'hcb;
      8'h20: r = 8'h54; 8'h21: r = 8'h7b; 8'h22: r = 8'h94; 8'h23: r = 8'h32; 8'h24: r = 8'ha6; 8'h25: r = 8'hc2; 8'h26: r = 8'h23; 8'h27: r = 8'h3d;
      8'h28: r = 8'hee; 8'h29: r = 8'h4c; 8'h2a: r = 8'h95; 8'h2b: r = 8'h0b; 8'h2c: r = 8'h42; 8'h2d: r = 8'hfa; 8'h2e: r = 8'hc3; 8'h2f: r = 8'h4e;
      8'h30: r = 8'h08; 8'h31: r = 8'h2e; 8'h32: r = 8'ha1; 8'h33: r = 8'h66; 8'h34: r = 8'h28; 8'h35: r = 8'hd9; 8'h36: r = 8'h24; 8'h37: r = 8'hb2;
      8'h38: r = 8'h76; 8'h39: r = 8'h5b; 8'h3a: r = 8'ha2; 8'h3b: r = 8'h49; 8'h3c: r = 8'h6d; 8'h3d: r = 8'h8b; 8'h3e: r = 8'hd1; 8'h3f: r = 8'h25;
      8'h40: r = 8'h72; 8'h41: r = 8'hf8; 8'h42: r = 8'hf6; 8'h43: r = 8'h64; 8'h44: r = 8'h86; 8'h45: r = 8'h68; 8'h46: r = 8'h98; 8'h47: r = 8'h16;
      8'h48: r = 8'hd4; 8'h49: r = 8'ha4; 8'h4a: r = 8'h5c; 8'h4b: r = 8'hcc; 8'h4c: r = 8'h5d; 8'h4d: r = 8'h65; 8'h4e: r = 8'hb6; 8'h4f: r = 8'h92;
      8'h50: r = 8'h6c; 8'h51: r = 8'h70; 8'h52: r = 8'h48; 8'h53: r = 8'h50; 8'h54: r = 8'hfd; 8'h55: r = 8'hed; 8'h56: r = 8'hb9; 8'h57: r = 8'hda;
      8'h58: r = 8'h5e; 8'h59: r = 8'h15; 8'h5a: r = 8'h46; 8'h5b: r = 8'h57; 8'h5c: r = 8'ha7; 8'h5d: r = 8'h8d; 8'h5e: r = 8'h9d; 8'h5f: r = 8'h84;
      8'h60: r = 8'h90; 8'h61: r = 8'hd8; 8'h62: r = 8'hab; 8'h63: r = 8'h00; 8'h64: r = 8'h8c; 8'h65: r = 8'hbc; 8'h66: r = 8'hd3; 8'h67: r = 8'h0a;
      8'h68: r = 8'hf7; 8'h69: r = 8'he4; 8'h6a: r = 8'h58; 8'h6b: r = 8'h05; 8'h6c: r = 8'hb8; 8'h6d: r = 8'hb3; 8'h6e: r = 8'h45; 8'h6f: r = 8'h06;
      8'h70: r = 8'hd0; 8'h71: r = 8'h2c; 8'h72: r = 8'h1e; 8'h73: r = 8'h8f; 8'h74: r = 8'hca; 8'h75: r = 8'h3f; 8'h76: r = 8'h0f; 8'h77: r = 8'h02;
      8'h78: r = 8'hc1; 8'h79: r = 8'haf; 8'h7a: r = 8'hbd; 8'h7b: r = 8'h03; 8'h7c: r = 8'h01; 8'h7d: r = 8'h13; 8'h7e: r = 8'h8a; 8'h7f: r = 8'h6b;
      8'h80: r = 8'h3a; 8'h81: r = 8'h91; 8'h82: r = 8'h11; 8'h83: r = 8'h41; 8'h84: r = 8'h4f; 8'h85: r = 8'h67; 8'h86: r = 8'hdc; 8'h87: r = 8'hea;
      8'h88: r = 8'h97; 8'h89: r = 8'hf2; 8'h8a: r = 8'hcf; 8'h8b: r = 8'hce; 8'h8c: r = 8'hf0; 8'h8d: r = 8'hb4; 8'h8e: r = 8'he6; 8'h8f: r = 8'h73;
      8'h90: r = 8'h96; 8'h91: r = 8'hac; 8'h92: r = 8'h74; 8'h93: r = 8'h22; 8'h94: r = 8'he7; 8'h95: r = 8'had; 8'h96: r = 8'h35; 8'h97: r = 8'h85;
      8'h98: r = 8'he2; 8'h99: r = 8'hf9; 8'h9a: r = 8'h37; 8'h9b: r = 8'he8; 8'h9c: r = 8'h1c; 8'h9d: r = 8'h75; 8'h9e: r = 8'hdf; 8'h9f: r = 8'h6e;
      8'ha0: r = 8'h47; 8'ha1: r = 8'hf1; 8'ha2: r = 8'h1a; 8'ha3: r = 8'h71; 8'ha4: r = 8'h1d; 8'ha5: r = 8'h29; 8'ha6: r = 8'hc5; 8'ha7: r = 8'h89;
      8'ha8: r = 8'h6f; 8'ha9: r = 8'hb7; 8'haa: r = 8'h62; 8'hab: r = 8'h0e; 8'hac: r = 8'haa; 8'had: r = 8'h18; 8'hae: r = 8'hbe; 8'haf: r = 8'h1b;
      8'hb0: r = 8'hfc; 8'hb1: r = 8'h56; 8'hb2: r = 8'h3e; 8'hb3: r = 8'h4b; 8'hb4: r = 8'hc6; 8'hb5: r = 8'hd2; 8'hb6: r = 8'h79; 8'hb7: r = 8'h20;
      8'hb8: r = 8'h9a; 8'hb9: r = 8'hdb; 8'hba: r = 8'hc0; 8'hbb: r = 8'hfe; 8'hbc: r = 8'h78; 8'hbd: r = 8'hcd; 8'hbe: r = 8'h5a; 8'hbf: r = 8'hf4;
      8'hc0: r = 8'h1f; 8'hc1: r = 8'hdd; 8'hc2: r = 8'ha8; 8'hc3: r = 8'h33; 8'hc4: r = 8'h88; 8'hc5: r = 8'h07; 8'hc6: r = 8'hc7; 8'hc7: r = 8'h31;
      8'hc8: r = 8'hb1; 8'hc9: r = 8'h12; 8'hca: r = 8'h10; 8'hcb: r = 8'h59; 8'hcc: r = 8'h27; 8'hcd: r = 8'h80; 8'hce: r = 8'hec; 8'hcf: r = 8'h5f;
      8'hd0: r = 8'h60; 8'hd1: r = 8'h51; 8'hd2: r = 8'h7f; 8'hd3: r = 8'ha9; 8'hd4: r = 8'h19; 8'hd5: r = 8'hb5; 8'hd6: r = 8'h4a; 8'hd7: r = 8'h0d;
      8'hd8: r = 8'h2d; 8'hd9: r = 8'he5; 8'hda: r = 8'h7a; 8'hdb: r = 8'h9f; 8'hdc: r = 8'h93; 8'hdd: r = 8'hc9; 8'hde: r = 8'h9c; 8'hdf: r = 8'hef;
      8'he0: r = 8'ha0; 8'he1: r = 8'he0; 8'he2: r = 8'h3b; 8'he3: r = 8'h4d; 8'he4: r = 8'hae; 8'he5: r = 8'h2a; 8'he6: r = 8'hf5; 8'he7: r = 8'hb0;
      8'he8: r = 8'hc8; 8'he9: r = 8'heb; 8'hea: r = 8'hbb; 8'heb: r = 8'h3c; 8'hec: r = 8'h83; 8'hed: r = 8'h53; 8'hee: r = 8'h99; 8'hef: r = 8'h61;
      8'hf0: r = 8'h17; 8'hf1: r = 8'h2b; 8'hf2: r = 8'h04; 8'hf3: r = 8'h7e; 8'hf4: r = 8'hba; 8'hf5: r = 8'h77; 8'hf6: r = 8'hd6; 8'hf7: r = 8'h26;
      8'hf8: r = 8'he1; 8'hf9: r = 8'h69; 8'hfa: r = 8'h14; 8'hfb: r = 8'h63; 8'hfc: r = 8'h55; 8'hfd: r = 8'h21; 8'hfe: r = 8'h0c; 8'hff: r = 8'h7d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_inv_cipher_iter_if.sv
// Request/response bundle between the self-check top and the inverse cipher.
interface aes_inv_cipher_iter_if;
  logic                      start;
  logic [1:0]                mode;
  logic [127:0]              ct_in;
  logic [aes_pkg::KS_W-1:0]  key_sched;
  logic [127:0]              pt_out;
  logic                      busy;
  logic                      done;
  logic                      err;

  modport master (output start, mode, ct_in, key_sched, input pt_out, busy, done, err);
  modport slave  (input start, mode, ct_in, key_sched, output pt_out, busy, done, err);
endinterface

// File: rtl/aes_inv_round.sv
// One combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns unless this is the last round.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] rk_i,
  input  logic         last_i,
  output logic [127:0] state_o
);

  // Indexed [column][row]; AES byte k lives at column k/4, row k%4.
  logic [3:0][3:0][7:0] ak, mc;

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_sub
      // Row r rotates right by r: output column c takes input column c-r.
      localparam int SRC = 4 * ((c - r + 4) % 4) + r;
      assign ak[c][r] = inv_sbox(state_i[127-8*SRC -: 8]) ^ rk_i[127-8*(4*c+r) -: 8];
    end
    for (genvar r = 0; r < 4; r++) begin : g_mix
      assign mc[c][r] = gf_mul_e(ak[c][r])           ^ gf_mul_b(ak[c][(r+1)%4]) ^
                        gf_mul_d(ak[c][(r+2)%4])     ^ gf_mul_9(ak[c][(r+3)%4]);
    end
    assign state_o[127-32*c -: 32] = last_i ? {ak[c][0], ak[c][1], ak[c][2], ak[c][3]}
                                            : {mc[c][0], mc[c][1], mc[c][2], mc[c][3]};
  end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128/192/256 decryptor, one round per clock, start/busy/done handshake.
// The key schedule is read live from the bus and must stay stable until done.
module aes_inv_cipher_iter
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  aes_inv_cipher_iter_if.slave bus
);

  fsm_e         fsm_q, fsm_d;
  logic [127:0] state_r, pt_q, rk, nxt;
  logic [3:0]   round_ctr, nr_sel, rk_idx;
  logic [10:0]  rk_base;
  logic         busy_q, done_q, err_q;
  logic         do_start, do_err, last;

  always_comb begin
    nr_sel = NR_128;
    case (mode_e'(bus.mode))
      MODE_192: nr_sel = NR_192;
      MODE_256: nr_sel = NR_256;
      default:  nr_sel = NR_128;
    endcase
  end

  // In IDLE the initial AddRoundKey needs rk(Nr); FINAL reaches rk(0) as round_ctr hits 0.
  assign rk_idx  = (fsm_q == ST_IDLE) ? nr_sel : round_ctr;
  assign rk_base = 11'(KS_W - 1) - {rk_idx, 7'd0};
  assign rk      = bus.key_sched[rk_base -: 128];
  assign last    = (fsm_q == ST_FINAL);

  aes_inv_round u_round (
    .state_i (state_r),
    .rk_i    (rk),
    .last_i  (last),
    .state_o (nxt)
  );

  // Start is not taken while done is high, so a held start yields one block per Nr+2 cycles.
  always_comb begin
    fsm_d    = fsm_q;
    do_start = 1'b0;
    do_err   = 1'b0;
    case (fsm_q)
      ST_IDLE: begin
        if (bus.start && !done_q) begin
          if (mode_e'(bus.mode) == MODE_RSV) begin
            do_err = 1'b1;
          end else begin
            do_start = 1'b1;
            fsm_d    = ST_ROUND;
          end
        end
      end
      ST_ROUND: if (round_ctr == 4'd1) fsm_d = ST_FINAL;
      ST_FINAL: fsm_d = ST_IDLE;
      default:  fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm_q <= ST_IDLE;
    else        fsm_q <= fsm_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= '0;
      round_ctr <= '0;
      pt_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= do_err;
      case (fsm_q)
        ST_IDLE: begin
          if (do_start) begin
            state_r   <= bus.ct_in ^ rk;
            round_ctr <= nr_sel - 4'd1;
            busy_q    <= 1'b1;
          end
        end
        ST_ROUND: begin
          state_r   <= nxt;
          round_ctr <= round_ctr - 4'd1;
        end
        ST_FINAL: begin
          state_r <= nxt;
          pt_q    <= nxt;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.pt_out = pt_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;

endmodule
